// File: rtl/hpdcache_mem_req_id_tracker.sv
// hpdcache_mem_req_id_tracker: tags memory reads with free-FIFO IDs and returns responses with their recorded metadata
module hpdcache_mem_req_id_tracker #(
  parameter int NIDS = 8,
  parameter int ADDR_WIDTH = 40,
  parameter int META_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  localparam int IDW = $clog2(NIDS),
  localparam int CW = $clog2(NIDS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_req_valid_i,
  output logic                  core_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] core_req_addr_i,
  input  logic [META_WIDTH-1:0] core_req_meta_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [IDW-1:0]        mem_req_id_o,
  input  logic                  free_rok_i,
  output logic                  free_r_o,
  input  logic [IDW-1:0]        free_id_i,
  input  logic                  free_wok_i,
  output logic                  free_w_o,
  output logic [IDW-1:0]        free_id_o,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  logic [IDW-1:0]        mem_resp_id_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
  output logic                  core_resp_valid_o,
  input  logic                  core_resp_ready_i,
  output logic [META_WIDTH-1:0] core_resp_meta_o,
  output logic [DATA_WIDTH-1:0] core_resp_data_o,
  output logic [CW-1:0]         outstanding_o,
  output logic                  err_o
);
  logic [NIDS-1:0] pending_q, pending_d;
  logic [META_WIDTH-1:0] meta_q [NIDS];
  logic [META_WIDTH-1:0] meta_d [NIDS];
  logic mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [IDW-1:0] mem_req_id_q, mem_req_id_d;
  logic core_resp_valid_q, core_resp_valid_d;
  logic [META_WIDTH-1:0] core_resp_meta_q, core_resp_meta_d;
  logic [DATA_WIDTH-1:0] core_resp_data_q, core_resp_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic req_acc, resp_acc, rel;

  assign core_req_ready_o  = free_rok_i & (~mem_req_valid_q | mem_req_ready_i);
  assign mem_resp_ready_o  = (~core_resp_valid_q | core_resp_ready_i) & free_wok_i;
  assign req_acc           = core_req_valid_i & core_req_ready_o;
  assign resp_acc          = mem_resp_valid_i & mem_resp_ready_o;
  assign rel               = resp_acc & pending_q[mem_resp_id_i];
  assign free_r_o          = req_acc;
  assign free_w_o          = rel;
  assign free_id_o         = mem_resp_id_i;
  assign mem_req_valid_o   = mem_req_valid_q;
  assign mem_req_addr_o    = mem_req_addr_q;
  assign mem_req_id_o      = mem_req_id_q;
  assign core_resp_valid_o = core_resp_valid_q;
  assign core_resp_meta_o  = core_resp_meta_q;
  assign core_resp_data_o  = core_resp_data_q;
  assign outstanding_o     = cnt_q;
  assign err_o             = err_q;

  // a released ID cannot be at the FIFO head this cycle, so set and clear never collide
  always_comb begin
    pending_d = pending_q;
    meta_d = meta_q;
    if (req_acc) begin
      pending_d[free_id_i] = 1'b1;
      meta_d[free_id_i] = core_req_meta_i;
    end
    if (rel) pending_d[mem_resp_id_i] = 1'b0;
    mem_req_valid_d   = req_acc | (mem_req_valid_q & ~mem_req_ready_i);
    mem_req_addr_d    = req_acc ? core_req_addr_i : mem_req_addr_q;
    mem_req_id_d      = req_acc ? free_id_i : mem_req_id_q;
    core_resp_valid_d = rel | (core_resp_valid_q & ~core_resp_ready_i);
    core_resp_meta_d  = rel ? meta_q[mem_resp_id_i] : core_resp_meta_q;
    core_resp_data_d  = rel ? mem_resp_data_i : core_resp_data_q;
    cnt_d             = cnt_q + CW'(req_acc) - CW'(rel);
    err_d             = err_q | (resp_acc & ~pending_q[mem_resp_id_i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q         <= '0;
      mem_req_valid_q   <= 1'b0;
      core_resp_valid_q <= 1'b0;
      cnt_q             <= '0;
      err_q             <= 1'b0;
    end else begin
      pending_q         <= pending_d;
      mem_req_valid_q   <= mem_req_valid_d;
      core_resp_valid_q <= core_resp_valid_d;
      cnt_q             <= cnt_d;
      err_q             <= err_d;
    end
  end

  // payloads are qualified by their valid flags and need no reset
  always_ff @(posedge clk_i) begin
    meta_q           <= meta_d;
    mem_req_addr_q   <= mem_req_addr_d;
    mem_req_id_q     <= mem_req_id_d;
    core_resp_meta_q <= core_resp_meta_d;
    core_resp_data_q <= core_resp_data_d;
  end
endmodule

// File: tb/tb_hpdcache_mem_req_id_tracker.sv
// tb_hpdcache_mem_req_id_tracker: scoreboard bench with a free-ID FIFO model around the tracker
module tb_hpdcache_mem_req_id_tracker;
  localparam int NIDS = 8, AW = 40, MW = 16, DW = 64, IDW = 3, CW = 4;
  logic clk, rst_i;
  logic core_req_valid_i, core_req_ready_o;
  logic [AW-1:0] core_req_addr_i, mem_req_addr_o;
  logic [MW-1:0] core_req_meta_i, core_resp_meta_o;
  logic mem_req_valid_o, mem_req_ready_i;
  logic [IDW-1:0] mem_req_id_o, free_id_i, free_id_o, mem_resp_id_i;
  logic free_rok_i, free_r_o, free_wok_i, free_w_o;
  logic mem_resp_valid_i, mem_resp_ready_o;
  logic [DW-1:0] mem_resp_data_i, core_resp_data_o;
  logic core_resp_valid_o, core_resp_ready_i;
  logic [CW-1:0] outstanding_o;
  logic err_o;

  hpdcache_mem_req_id_tracker #(.NIDS(NIDS), .ADDR_WIDTH(AW), .META_WIDTH(MW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_addr_i(core_req_addr_i), .core_req_meta_i(core_req_meta_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .free_rok_i(free_rok_i), .free_r_o(free_r_o), .free_id_i(free_id_i),
    .free_wok_i(free_wok_i), .free_w_o(free_w_o), .free_id_o(free_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_id_i(mem_resp_id_i), .mem_resp_data_i(mem_resp_data_i),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_ready_i(core_resp_ready_i),
    .core_resp_meta_o(core_resp_meta_o), .core_resp_data_o(core_resp_data_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-ID FIFO, reset to 0..NIDS-1 with 0 at the head
  logic [IDW-1:0] fmem [NIDS];
  logic [IDW-1:0] frd, fwr;
  logic [CW-1:0] fcnt;
  assign free_rok_i = fcnt != 0;
  assign free_wok_i = fcnt != CW'(NIDS);
  assign free_id_i  = fmem[frd];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < NIDS; i++) fmem[i] <= IDW'(i);
      frd <= '0;
      fwr <= '0;
      fcnt <= CW'(NIDS);
    end else begin
      if (free_r_o) frd <= frd + 1'b1;
      if (free_w_o) begin
        fmem[fwr] <= free_id_o;
        fwr <= fwr + 1'b1;
      end
      fcnt <= fcnt + CW'(free_w_o) - CW'(free_r_o);
    end
  end

  int n_cmp = 0, n_bad = 0, n_pop = 0;
  logic [AW+IDW-1:0] q_mreq [$];
  logic [MW+DW-1:0] q_cresp [$];
  logic [IDW-1:0] q_free [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [AW+IDW-1:0] em;
  logic [MW+DW-1:0] ec;
  logic [IDW-1:0] ef;
  always @(negedge clk) if (!rst_i) begin
    if (free_r_o) n_pop++;
    if (mem_req_valid_o && mem_req_ready_i) begin
      if (q_mreq.size() == 0) chk("mreq_unexpected", 1, 0);
      else begin
        em = q_mreq.pop_front();
        chk("mreq_addr", 64'(mem_req_addr_o), 64'(em[AW+IDW-1:IDW]));
        chk("mreq_id", 64'(mem_req_id_o), 64'(em[IDW-1:0]));
      end
    end
    if (core_resp_valid_o && core_resp_ready_i) begin
      if (q_cresp.size() == 0) chk("cresp_unexpected", 1, 0);
      else begin
        ec = q_cresp.pop_front();
        chk("cresp_meta", 64'(core_resp_meta_o), 64'(ec[MW+DW-1:DW]));
        chk("cresp_data", core_resp_data_o, ec[DW-1:0]);
      end
    end
    if (free_w_o) begin
      if (q_free.size() == 0) chk("free_unexpected", 1, 0);
      else begin
        ef = q_free.pop_front();
        chk("free_id", 64'(free_id_o), 64'(ef));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    core_req_valid_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    step();
  endtask

  task automatic req(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [IDW-1:0] id);
    core_req_valid_i = 1'b1;
    core_req_addr_i = a;
    core_req_meta_i = m;
    q_mreq.push_back({a, id});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_req_ready_o) break;
      if (i == 19) chk("req_timeout", 0, 1);
    end
    step();
  endtask

  task automatic resp(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic [MW-1:0] m);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i = id;
    mem_resp_data_i = d;
    q_cresp.push_back({m, d});
    q_free.push_back(id);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_resp_ready_o) break;
      if (i == 19) chk("resp_timeout", 0, 1);
    end
    step();
  endtask

  task automatic chk_reset;
    @(negedge clk);
    chk("rst_mreq_valid", 64'(mem_req_valid_o), 0);
    chk("rst_cresp_valid", 64'(core_resp_valid_o), 0);
    chk("rst_outstanding", 64'(outstanding_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_free_r", 64'(free_r_o), 0);
    chk("rst_free_w", 64'(free_w_o), 0);
    chk("rst_req_ready", 64'(core_req_ready_o), 1);
    step();
  endtask

  task automatic chk_cnt(input string nm, input int exp);
    @(negedge clk);
    chk(nm, 64'(outstanding_o), 64'(exp));
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_i = 1'b1;
    core_req_valid_i = 1'b0; core_req_addr_i = '0; core_req_meta_i = '0;
    mem_req_ready_i = 1'b1; core_resp_ready_i = 1'b1;
    mem_resp_valid_i = 1'b0; mem_resp_id_i = '0; mem_resp_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk_reset();
    for (int k = 0; k < NIDS; k++) req(40'h1000 + 40'(k) * 40'h40, 16'h1000 + 16'(k), IDW'(k));
    @(negedge clk);
    chk("drain_req_ready", 64'(core_req_ready_o), 0);
    chk("drain_outstanding", 64'(outstanding_o), 8);
    chk("drain_free_r", 64'(free_r_o), 0);
    step();
    idle();
    resp(3'd5, 64'hD5, 16'h1005);
    resp(3'd2, 64'hD2, 16'h1002);
    resp(3'd7, 64'hD7, 16'h1007);
    idle();
    chk_cnt("ooo_outstanding", 5);
    req(40'h2000, 16'h2000, 3'd5);
    req(40'h2040, 16'h2001, 3'd2);
    req(40'h2080, 16'h2002, 3'd7);
    idle();
    chk_cnt("refill_outstanding", 8);
    resp(3'd0, 64'hD0, 16'h1000);
    resp(3'd1, 64'hD1, 16'h1001);
    idle();
    chk_cnt("release2_outstanding", 6);
    // request backpressure: one accept, held payload
    mem_req_ready_i = 1'b0;
    core_req_valid_i = 1'b1; core_req_addr_i = 40'hABCDE; core_req_meta_i = 16'h3000;
    q_mreq.push_back({40'hABCDE, 3'd0});
    p0 = n_pop;
    @(negedge clk);
    chk("bp_first_ready", 64'(core_req_ready_o), 1);
    step();
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(core_req_ready_o), 0);
      chk("bp_mreq_valid", 64'(mem_req_valid_o), 1);
      chk("bp_mreq_addr", 64'(mem_req_addr_o), 64'hABCDE);
      chk("bp_mreq_id", 64'(mem_req_id_o), 0);
      step();
    end
    core_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    step();
    chk("bp_accept_count", 64'(n_pop - p0), 1);
    // response backpressure
    core_resp_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_id_i = 3'd0; mem_resp_data_i = 64'hE0;
    q_cresp.push_back({16'h3000, 64'hE0});
    q_free.push_back(3'd0);
    @(negedge clk);
    chk("rbp_first_ready", 64'(mem_resp_ready_o), 1);
    step();
    mem_resp_id_i = 3'd2; mem_resp_data_i = 64'hE2;
    repeat (3) begin
      @(negedge clk);
      chk("rbp_resp_ready", 64'(mem_resp_ready_o), 0);
      chk("rbp_free_w", 64'(free_w_o), 0);
      chk("rbp_cresp_valid", 64'(core_resp_valid_o), 1);
      chk("rbp_cresp_meta", 64'(core_resp_meta_o), 64'h3000);
      chk("rbp_cresp_data", core_resp_data_o, 64'hE0);
      step();
    end
    q_cresp.push_back({16'h2001, 64'hE2});
    q_free.push_back(3'd2);
    core_resp_ready_i = 1'b1;
    step();
    idle();
    chk_cnt("rbp_outstanding", 5);
    resp(3'd3, 64'hD3, 16'h1003);
    idle();
    chk_cnt("pre_reset_outstanding", 4);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_reset();
    req(40'h4000, 16'h4000, 3'd0);
    req(40'h4040, 16'h4001, 3'd1);
    req(40'h4080, 16'h4002, 3'd2);
    // simultaneous accept of ID 3 and release of ID 1
    core_req_valid_i = 1'b1; core_req_addr_i = 40'h40C0; core_req_meta_i = 16'h4003;
    q_mreq.push_back({40'h40C0, 3'd3});
    mem_resp_valid_i = 1'b1; mem_resp_id_i = 3'd1; mem_resp_data_i = 64'hF1;
    q_cresp.push_back({16'h4001, 64'hF1});
    q_free.push_back(3'd1);
    @(negedge clk);
    chk("sim_free_r", 64'(free_r_o), 1);
    chk("sim_free_w", 64'(free_w_o), 1);
    step();
    idle();
    chk_cnt("sim_outstanding", 3);
    // ID 1 was released, ID 4 never issued: both spurious
    for (int s = 0; s < 2; s++) begin
      mem_resp_valid_i = 1'b1; mem_resp_id_i = (s == 0) ? 3'd1 : 3'd4; mem_resp_data_i = 64'hBAD;
      @(negedge clk);
      chk("spur_resp_ready", 64'(mem_resp_ready_o), 1);
      chk("spur_free_w", 64'(free_w_o), 0);
      step();
      mem_resp_valid_i = 1'b0;
      @(negedge clk);
      chk("spur_cresp_valid", 64'(core_resp_valid_o), 0);
      chk("spur_err", 64'(err_o), 1);
      step();
    end
    repeat (3) step();
    chk_cnt("spur_outstanding", 3);
    @(negedge clk);
    chk("err_held", 64'(err_o), 1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_reset();
    chk("q_mreq_empty", 64'(q_mreq.size()), 0);
    chk("q_cresp_empty", 64'(q_cresp.size()), 0);
    chk("q_free_empty", 64'(q_free.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
